// File: rtl/mcdf_fifo_arbiter.sv
// Arbitrates among three slave FIFOs and drains one fixed-length packet per grant
// into the formatter port, one word in flight at a time.
module mcdf_fifo_arbiter #(
    parameter int DW      = 4,
    parameter int PKT_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2:0]      fifo_empty,
    input  logic [3*DW-1:0] fifo_data,
    output logic [2:0]      fifo_rd_n,
    input  logic [2:0]      cfg_en,
    input  logic            cfg_prio,
    output logic            fmt_valid,
    input  logic            fmt_ready,
    output logic [DW-1:0]   fmt_data,
    output logic [1:0]      fmt_ch,
    output logic            fmt_sop,
    output logic            fmt_eop,
    output logic            busy,
    output logic            pkt_done
);

    localparam int             CW       = $clog2(PKT_LEN) + 1;
    localparam logic [CW-1:0]  CNT_MAX  = CW'(PKT_LEN);
    localparam logic [CW-1:0]  CNT_LAST = CW'(PKT_LEN - 1);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      gnt, gnt_nxt, last;
    logic [CW-1:0]   rd_cnt, wr_cnt;
    logic            rd_pend;
    logic [2:0]      eligible;
    logic            accept;
    logic            rd_issue;
    logic [DW-1:0]   sel_data;

    // Round-robin: first eligible channel after ptr, wrapping 2 -> 0.
    function automatic logic [1:0] pick_rr(input logic [2:0] elig, input logic [1:0] ptr);
        logic [1:0] pick;
        int         s;
        pick = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            s = int'(ptr) + k;
            if (s >= 3) s = s - 3;
            if (elig[s]) pick = 2'(s);
        end
        return pick;
    endfunction

    function automatic logic [1:0] pick_fix(input logic [2:0] elig);
        if (elig[0])      return 2'd0;
        else if (elig[1]) return 2'd1;
        else              return 2'd2;
    endfunction

    assign eligible = cfg_en & ~fifo_empty;
    assign accept   = fmt_valid && fmt_ready;
    assign rd_issue = (state == XFER) && (rd_cnt < CNT_MAX) && !rd_pend
                      && (!fmt_valid || fmt_ready);
    assign busy     = (state == XFER);
    assign pkt_done = (state == DONE);

    always_comb begin
        sel_data = '0;
        case (gnt)
            2'd0:    sel_data = fifo_data[0*DW +: DW];
            2'd1:    sel_data = fifo_data[1*DW +: DW];
            2'd2:    sel_data = fifo_data[2*DW +: DW];
            default: sel_data = '0;
        endcase
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave a latch behind.
    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        fifo_rd_n = 3'b111;
        case (state)
            IDLE: begin
                if (|eligible) begin
                    state_nxt = XFER;
                    gnt_nxt   = cfg_prio ? pick_fix(eligible) : pick_rr(eligible, last);
                end
            end
            XFER: begin
                if (rd_issue) fifo_rd_n[gnt] = 1'b0;
                if (accept && fmt_eop) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 2'd0;
            last  <= 2'd2;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            if (state == DONE) last <= gnt;
        end
    end

    // A read issued in cycle t returns data in t+1; it is captured at the end of t+1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt    <= '0;
            wr_cnt    <= '0;
            rd_pend   <= 1'b0;
            fmt_valid <= 1'b0;
            fmt_data  <= '0;
            fmt_ch    <= 2'd0;
            fmt_sop   <= 1'b0;
            fmt_eop   <= 1'b0;
        end else begin
            rd_pend <= rd_issue;
            if (state == IDLE) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (rd_issue) rd_cnt <= rd_cnt + CW'(1);
                if (accept) begin
                    fmt_valid <= 1'b0;
                    wr_cnt    <= wr_cnt + CW'(1);
                end
                if (rd_pend) begin
                    fmt_valid <= 1'b1;
                    fmt_data  <= sel_data;
                    fmt_ch    <= gnt;
                    fmt_sop   <= (wr_cnt == '0);
                    fmt_eop   <= (wr_cnt == CNT_LAST);
                end
            end
        end
    end

endmodule

// File: doc/mcdf_fifo_arbiter.md
Name: mcdf_fifo_arbiter

Overview:
- Sequences reads from three slave FIFOs (4-bit data, low-active read, registered data_out) and feeds a single formatter port.
- Arbitrates among enabled, non-empty channels.
- Drains one fixed 4-word packet per grant. A slave FIFO deasserts empty only with at least 4 words stored, so a granted channel always holds a full packet.
- Sits between the slave FIFO array and the MCDF formatter.

Parameters:
- DW, 4, data word width; must equal the slave FIFO data width.
- PKT_LEN, 4, words per grant; must not exceed the slave FIFO empty threshold.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- fifo_empty  in  3  per-channel empty flag (bit i = channel i); high means fewer than 4 words.
- fifo_data  in  3*DW  per-channel data_out; channel i in bits [i*DW +: DW].
- fifo_rd_n  out  3  per-channel read strobe, active-low, one-hot-cold.
- cfg_en  in  3  channel enable; a disabled channel is never granted.
- cfg_prio  in  1  arbitration mode: 0 = round-robin, 1 = fixed priority ch0>ch1>ch2.
- fmt_valid  out  1  output word valid.
- fmt_ready  in  1  formatter accepts the word when fmt_valid && fmt_ready at a rising edge.
- fmt_data  out  DW  output word.
- fmt_ch  out  2  source channel of the current word (0..2).
- fmt_sop  out  1  high with the first word of a packet.
- fmt_eop  out  1  high with the last word of a packet.
- busy  out  1  high from grant until the last word is accepted.
- pkt_done  out  1  one-cycle pulse in the cycle after the eop word is accepted.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst_n low):
  - fifo_rd_n=3'b111; fmt_valid, fmt_sop, fmt_eop, busy, pkt_done = 0; fmt_data=0; fmt_ch=0.
  - State=IDLE; all counters 0.
  - Round-robin pointer last=2, so ch0 has highest round-robin priority after reset.
- State machine: IDLE -> XFER -> DONE -> IDLE.
- IDLE:
  - eligible[i] = cfg_en[i] && !fifo_empty[i].
  - If any channel is eligible, latch grant gnt and go to XFER; busy rises in the next cycle.
  - Round-robin: first eligible channel searching from last+1 upward, wrapping 2 -> 0.
  - Fixed priority: lowest eligible index.
  - No eligible channel: remain in IDLE; no reads.
- XFER, read issue:
  - At most one read in flight.
  - fifo_rd_n[gnt] is driven low for exactly one cycle t when all of the following hold:
    - rd_cnt < PKT_LEN;
    - no read was issued in cycle t-1;
    - the output stage is empty, or is being accepted in cycle t.
  - rd_cnt increments on each issued read.
- XFER, capture:
  - fifo_data[gnt] is valid during cycle t+1 and is registered into fmt_data at the end of t+1.
  - fmt_valid is high from cycle t+2, with fmt_ch=gnt.
  - fmt_sop=1 when wr_cnt==0; fmt_eop=1 when wr_cnt==PKT_LEN-1.
  - wr_cnt increments on each accepted word.
- Output hold: while fmt_valid && !fmt_ready, fmt_data, fmt_ch, fmt_sop and fmt_eop stay stable and no new read is issued.
- Throughput: one word per 2 cycles with fmt_ready held high.
- Leaving XFER: on acceptance of the eop word, go to DONE.
- DONE (one cycle):
  - pkt_done=1, busy=0.
  - last=gnt, updated in both modes.
  - Return to IDLE; arbitration resumes the following cycle.
- Configuration timing:
  - cfg_en and cfg_prio are sampled only in IDLE.
  - Clearing cfg_en[gnt] mid-packet does not abort the packet.
- fifo_empty[gnt] is ignored during XFER; the packet is guaranteed by the FIFO threshold.
- fifo_rd_n is never low for a channel other than gnt, and is never low outside XFER.
- Counter widths: rd_cnt and wr_cnt are clog2(PKT_LEN)+1 bits and never exceed PKT_LEN.
- Reset mid-packet:
  - Outstanding words are abandoned and fifo_rd_n returns high immediately.
  - The next grant after release follows the reset pointer (ch0 first).

Test Plan:
- Reset check: hold rst_n low, toggle inputs -> fifo_rd_n=3'b111, fmt_valid=0, busy=0, pkt_done=0 throughout.
- Single channel: only ch1 non-empty with data 1,2,3,4, cfg_en=3'b111, cfg_prio=0, fmt_ready=1 -> exactly 4 single-cycle pulses on fifo_rd_n[1], spaced 2 cycles apart.
  - Output 1,2,3,4 with fmt_ch=1, sop on word 1, eop on word 4.
  - pkt_done pulses once; fifo_rd_n[0] and fifo_rd_n[2] stay high.
- Round-robin: all three channels continuously non-empty, cfg_prio=0 -> packet order ch0, ch1, ch2, ch0, ch1.
  - Clearing cfg_en[1] before the 4th grant gives order ch0, ch2, ch0.
- Fixed priority: ch0 and ch2 continuously non-empty, cfg_prio=1 -> every packet from ch0.
  - After ch0 goes empty, the next packet comes from ch2.
- Backpressure: drop fmt_ready for 5 cycles while word 2 is valid -> fmt_data, sop and eop stable, no fifo_rd_n pulse during the stall.
  - All 4 words are delivered in order, with no duplicates.
- Reset mid-packet: assert rst_n low after word 2 is accepted from ch2 -> outputs go to reset values immediately.
  - After release with ch0 and ch2 both non-empty (cfg_prio=0), ch0 is granted first.
